// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO while idle, latches operands for an
// external combinational multiplier and an external iterative divider, stalls
// the pipeline until the result is written into the {HI,LO} register.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op_valid, op        EX-stage instruction valid / operation code
//   src_a, src_b        rs / rt operands
//   flush               cancel the EX instruction (aborts any operation)
//   mul_a/mul_b/mul_signed, mul_result   multiplier operands and product
//   div_start/div_cancel                 divider launch / abort pulses
//   div_a/div_b/div_signed               divider operands
//   div_done, div_result                 divider completion and {rem,quot}
//   muldiv_stall        pipeline stall request (combinational)
//   hilo                architectural {HI,LO}
//   busy                high whenever an operation is in flight
module muldiv_ctrl #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_signed,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_cancel,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_signed,
   input  logic        div_done,
   input  logic [63:0] div_result,
   output logic        muldiv_stall,
   output logic [63:0] hilo,
   output logic        busy
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [2:0] CNT_LOAD = 3'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV_LAUNCH, S_DIV} state_t;

   state_t     state;
   logic [2:0] cnt;

   logic accept, acc_md, in_div;

   assign accept = (state == S_IDLE) && op_valid && !flush;
   assign acc_md = accept && (op == OP_MULT || op == OP_MULTU ||
                              op == OP_DIV  || op == OP_DIVU);
   assign in_div = (state == S_DIV_LAUNCH) || (state == S_DIV);

   // Flush (and reset) silence stall and launch; the completion cycle drops
   // stall so the instruction retires on the same edge hilo is written.
   assign muldiv_stall = !rst && !flush &&
                         (acc_md ||
                          (state == S_DIV_LAUNCH) ||
                          (state == S_MUL && cnt != 3'd0) ||
                          (state == S_DIV && !div_done));
   assign div_start  = !rst && !flush && (state == S_DIV_LAUNCH);
   assign div_cancel = (rst || flush) && in_div;
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         hilo       <= 64'd0;
         mul_a      <= 32'd0;
         mul_b      <= 32'd0;
         mul_signed <= 1'b0;
         div_a      <= 32'd0;
         div_b      <= 32'd0;
         div_signed <= 1'b0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= 3'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (op_valid) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        mul_a      <= src_a;
                        mul_b      <= src_b;
                        mul_signed <= (op == OP_MULT);
                        cnt        <= CNT_LOAD;
                        state      <= S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        div_a      <= src_a;
                        div_b      <= src_b;
                        div_signed <= (op == OP_DIV);
                        state      <= S_DIV_LAUNCH;
                     end
                     OP_MTHI: hilo[63:32] <= src_a;
                     OP_MTLO: hilo[31:0]  <= src_a;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               if (cnt == 3'd0) begin
                  hilo  <= mul_result;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_DIV_LAUNCH: state <= S_DIV;
            S_DIV: begin
               if (div_done) begin
                  hilo  <= div_result;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: a directed per-cycle vector table, a short
// hand-written operand-latch sequence, then randomized instructions checked
// against an instruction-level model (stall count, hilo result, pulses).
module tb_muldiv_ctrl;
   localparam int MC = 2;

   logic        clk = 1'b0;
   logic        rst, op_valid, flush, div_done;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic [63:0] mul_result, div_result;
   logic [31:0] mul_a, mul_b, div_a, div_b;
   logic        mul_signed, div_signed, div_start, div_cancel, muldiv_stall, busy;
   logic [63:0] hilo;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a),
      .src_b(src_b), .flush(flush), .mul_a(mul_a), .mul_b(mul_b),
      .mul_signed(mul_signed), .mul_result(mul_result), .div_start(div_start),
      .div_cancel(div_cancel), .div_a(div_a), .div_b(div_b),
      .div_signed(div_signed), .div_done(div_done), .div_result(div_result),
      .muldiv_stall(muldiv_stall), .hilo(hilo), .busy(busy)
   );

   typedef struct {
      bit          r, ov, fl, dd;
      logic [2:0]  o;
      logic [31:0] a, b;
      logic [63:0] mr, dr;
      bit          e_stall, e_start, e_cancel, e_busy;
      logic [63:0] e_hilo;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_v(input bit r, input bit ov, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input bit fl,
                        input logic [63:0] mr, input bit dd, input logic [63:0] dr,
                        input bit es, input bit est, input bit ec, input bit eb,
                        input logic [63:0] eh);
      vec_t v;
      v.r = r; v.ov = ov; v.o = o; v.a = a; v.b = b; v.fl = fl; v.mr = mr;
      v.dd = dd; v.dr = dr; v.e_stall = es; v.e_start = est; v.e_cancel = ec;
      v.e_busy = eb; v.e_hilo = eh;
      vecs.push_back(v);
   endtask

   task automatic set_in(input bit r, input bit ov, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit fl, input bit dd);
      @(negedge clk);
      rst = r; op_valid = ov; op = o; src_a = a; src_b = b; flush = fl; div_done = dd;
   endtask

   // instruction-level reference values
   function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (o == 3'd1) return sa * sb;
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};  // arbitrary divider answer
      if (o == 3'd3) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      return {a % b, a / b};
   endfunction

   initial begin
      logic [63:0] h;
      rst = 1'b1; op_valid = 0; op = 0; src_a = 0; src_b = 0; flush = 0;
      div_done = 0; mul_result = 0; div_result = 0;

      //    r ov op  src_a         src_b        fl mul_result              dd div_result              st sta can bsy hilo_after
      add_v(1, 0, 0, 0,            0,            0, 0,                      0, 0,                      0, 0, 0, 0, 64'h0);
      add_v(0, 1, 5, 32'h12345678, 0,            0, 0,                      0, 0,                      0, 0, 0, 0, 64'h12345678_00000000);
      add_v(0, 1, 6, 32'h9ABCDEF0, 0,            0, 0,                      0, 0,                      0, 0, 0, 0, 64'h12345678_9ABCDEF0);
      h = 64'h12345678_9ABCDEF0;
      add_v(0, 1, 1, 32'hFFFFFFFE, 3,            0, 64'hFFFFFFFF_FFFFFFFA,  0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 1, 32'hFFFFFFFE, 3,            0, 64'hFFFFFFFF_FFFFFFFA,  0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 1, 32'hFFFFFFFE, 3,            0, 64'hFFFFFFFF_FFFFFFFA,  0, 0,                      0, 0, 0, 0, 64'hFFFFFFFF_FFFFFFFA);
      h = 64'hFFFFFFFF_FFFFFFFA;
      add_v(0, 1, 4, 100,          7,            0, 0,                      0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 4, 100,          7,            0, 0,                      0, 0,                      1, 1, 0, 1, h);
      for (int i = 0; i < 3; i++)
         add_v(0, 1, 4, 100,       7,            0, 0,                      0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 4, 100,          7,            0, 0,                      1, 64'h00000002_0000000E,  0, 0, 0, 0, 64'h00000002_0000000E);
      h = 64'h00000002_0000000E;
      add_v(0, 1, 3, 32'hFFFFFFEC, 3,            0, 0,                      0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 3, 32'hFFFFFFEC, 3,            0, 0,                      0, 0,                      1, 1, 0, 1, h);
      add_v(0, 1, 3, 32'hFFFFFFEC, 3,            0, 0,                      0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 3, 32'hFFFFFFEC, 3,            1, 0,                      0, 0,                      0, 0, 1, 0, h);
      add_v(0, 0, 3, 0,            0,            0, 0,                      1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 0, 0, h);
      add_v(0, 1, 2, 5,            6,            0, 30,                     0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 2, 5,            6,            0, 30,                     0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 2, 5,            6,            1, 30,                     0, 0,                      0, 0, 0, 0, h);
      add_v(0, 1, 2, 7,            8,            0, 56,                     0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 2, 7,            8,            0, 56,                     0, 0,                      1, 0, 0, 1, h);
      add_v(0, 1, 2, 7,            8,            0, 56,                     0, 0,                      0, 0, 0, 0, 64'd56);
      add_v(0, 1, 3, 9,            2,            0, 0,                      0, 0,                      1, 0, 0, 1, 64'd56);
      add_v(0, 1, 3, 9,            2,            0, 0,                      0, 0,                      1, 1, 0, 1, 64'd56);
      add_v(0, 1, 3, 9,            2,            0, 0,                      0, 0,                      1, 0, 0, 1, 64'd56);
      add_v(1, 1, 3, 9,            2,            0, 0,                      0, 0,                      0, 0, 1, 0, 64'd0);
      add_v(0, 0, 0, 0,            0,            0, 0,                      0, 0,                      0, 0, 0, 0, 64'd0);
      add_v(0, 1, 7, 32'hFFFF,     1,            0, 64'h55,                 1, 64'h66,                 0, 0, 0, 0, 64'd0);
      add_v(0, 1, 5, 32'hAAAA,     0,            1, 0,                      0, 0,                      0, 0, 0, 0, 64'd0);
      add_v(0, 0, 1, 3,            3,            0, 64'h9,                  0, 0,                      0, 0, 0, 0, 64'd0);
      add_v(0, 1, 4, 10,           2,            0, 0,                      0, 0,                      1, 0, 0, 1, 64'd0);
      add_v(0, 1, 4, 10,           2,            1, 0,                      0, 0,                      0, 0, 1, 0, 64'd0);
      add_v(0, 0, 0, 0,            0,            0, 0,                      1, 64'h77,                 0, 0, 0, 0, 64'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].r; op_valid = vecs[i].ov; op = vecs[i].o; src_a = vecs[i].a;
         src_b = vecs[i].b; flush = vecs[i].fl; mul_result = vecs[i].mr;
         div_done = vecs[i].dd; div_result = vecs[i].dr;
         #1;
         chk($sformatf("vec%0d stall", i), 64'(muldiv_stall), 64'(vecs[i].e_stall));
         chk($sformatf("vec%0d div_start", i), 64'(div_start), 64'(vecs[i].e_start));
         chk($sformatf("vec%0d div_cancel", i), 64'(div_cancel), 64'(vecs[i].e_cancel));
         @(posedge clk); #1;
         chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
         chk($sformatf("vec%0d hilo", i), hilo, vecs[i].e_hilo);
      end

      // operand latches hold across aborts and unrelated accepts
      set_in(1, 0, 0, 0, 0, 0, 0);
      set_in(0, 1, 3, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      @(posedge clk); #1;
      chk("latch div_a", 64'(div_a), 64'h80000000);
      chk("latch div_b", 64'(div_b), 64'hFFFFFFFF);
      chk("latch div_signed", 64'(div_signed), 64'd1);
      set_in(0, 1, 3, 0, 0, 1, 0);
      #1 chk("latch cancel", 64'(div_cancel), 64'd1);
      set_in(0, 1, 2, 32'hAAAA5555, 32'h0000FFFF, 0, 0);
      @(posedge clk); #1;
      chk("latch mul_a", 64'(mul_a), 64'hAAAA5555);
      chk("latch mul_b", 64'(mul_b), 64'h0000FFFF);
      chk("latch mul_signed", 64'(mul_signed), 64'd0);
      set_in(0, 1, 2, 0, 0, 1, 0);
      set_in(0, 1, 6, 32'h1, 32'h2, 0, 0);
      @(posedge clk); #1;
      chk("hold mul_a", 64'(mul_a), 64'hAAAA5555);
      chk("hold div_a", 64'(div_a), 64'h80000000);
      chk("hold div_signed", 64'(div_signed), 64'd1);

      // randomized instructions vs. instruction-level model
      set_in(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      h = 64'd0;
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         logic [63:0] prod, dres;
         int lat, n_stall, flush_at;
         bit is_mul, is_div;
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         lat = $urandom_range(1, 5);
         is_mul = (o == 3'd1 || o == 3'd2);
         is_div = (o == 3'd3 || o == 3'd4);
         n_stall = is_mul ? MC : (is_div ? lat + 1 : 0);
         flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n_stall) : -1;
         prod = ref_mul(o, a, b);
         dres = ref_div(o, a, b);
         for (int c = 0; c <= n_stall; c++) begin
            @(negedge clk);
            rst = 0; op_valid = 1; op = o; src_a = a; src_b = b;
            flush = (c == flush_at);
            mul_result = is_mul ? prod : {$urandom, $urandom};
            div_result = is_div ? dres : {$urandom, $urandom};
            div_done = is_div ? (c == lat + 1) : 1'($urandom_range(0, 1));
            #1;
            chk("rnd stall", 64'(muldiv_stall), 64'((c != flush_at) && (c < n_stall)));
            chk("rnd div_start", 64'(div_start), 64'(is_div && c == 1 && c != flush_at));
            chk("rnd div_cancel", 64'(div_cancel), 64'(is_div && c == flush_at && c >= 1));
            @(posedge clk); #1;
            if (c == flush_at || c == n_stall) begin
               if (flush_at < 0) begin
                  case (o)
                     3'd1, 3'd2: h = prod;
                     3'd3, 3'd4: h = dres;
                     3'd5: h[63:32] = a;
                     3'd6: h[31:0] = a;
                     default: ;
                  endcase
               end
               chk("rnd hilo", hilo, h);
               chk("rnd busy end", 64'(busy), 64'd0);
               break;
            end
            chk("rnd busy", 64'(busy), 64'd1);
         end
         if ($urandom_range(0, 3) == 0) begin
            set_in(0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1 chk("bubble stall", 64'(muldiv_stall), 64'd0);
            @(posedge clk); #1;
            chk("bubble hilo", hilo, h);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
